computer_system_pio_dispatch: RTL
=================================

Name: computer_system_pio_dispatch

Overview:
- Avalon-MM slave output PIO. The HPS writes values over the lightweight bridge, and the block delivers each value to FPGA fabric logic on a valid/ready handshake.
- It is the write-direction counterpart of the read-only input PIOs on the same bus.
- One-deep pending buffer so the HPS never stalls. Sticky overflow flag when an undelivered value is superseded. 16-bit delivered-transfer counter.

Parameters:
- WIDTH, 8, width of the data register and out_port (1..16)
- RESET_VALUE, 0, reset value of the data register and out_port

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous assert, active-low (one clock; reset asynchronous active-low)
- address  input  2  Avalon word address
- chipselect  input  1  Avalon chip select
- write_n  input  1  Avalon write strobe, active-low
- writedata  input  32  Avalon write data
- readdata  output  32  Avalon read data, registered
- out_port  output  WIDTH  value presented to fabric
- out_valid  output  1  out_port holds an undelivered value
- out_ready  input  1  fabric accepts out_port this cycle

Behaviour:
- wr = chipselect & ~write_n. Reads have no side effects.
- readdata is updated every clock from the address mux, with 1-cycle latency.
  - Address 0 returns the zero-extended data register.
  - Address 1 returns STATUS.
  - Addresses 2 and 3 return 0.
- Register map:
  - Address 0, DATA: write sets data_reg = writedata[WIDTH-1:0].
  - Address 1, STATUS: bit0 = out_valid, bit1 = pending, bit2 = overflow, bits[31:16] = xfer_count. Writing 1 to bit2 clears overflow; all other bits are read-only.
  - Address 2, SET: data_reg |= writedata[WIDTH-1:0].
  - Address 3, CLEAR: data_reg &= ~writedata[WIDTH-1:0].
- A "load" is a write to address 0, 2 or 3. It is counted even if the value is unchanged.
  - data_next = post-write value of data_reg.
- Transfer: out_valid & out_ready in a cycle. xfer_count increments on each transfer and wraps at 0xFFFF to 0.
- State machine, registered:
  - IDLE: out_valid=0.
    - Load -> out_port<=data_next; go to SENT.
  - SENT: out_valid=1, pending=0.
    - Transfer, no load -> IDLE.
    - Load, no transfer -> SENT_PEND; out_port unchanged.
    - Transfer and load together -> out_port<=data_next; stay SENT.
  - SENT_PEND: out_valid=1, pending=1. data_reg holds the newer value.
    - Transfer, no load -> out_port<=data_reg; go to SENT.
    - Load, no transfer -> overflow<=1; stay SENT_PEND. The pending value is superseded.
    - Transfer and load together -> out_port<=data_next; overflow<=1; go to SENT.
- out_port is stable whenever out_valid=1 and no transfer occurs.
- Overflow write-1 clear and overflow set in the same cycle: set wins.
- Reset, at any time including mid-handshake:
  - State IDLE; out_valid=0.
  - out_port = data_reg = RESET_VALUE.
  - overflow=0, xfer_count=0, readdata=0.
- The fabric must not depend on out_ready being held; out_ready while out_valid=0 is ignored.
- writedata bits above WIDTH are ignored.

Decomposition:
- Shared package pio_dispatch_pkg:
  - Address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_SET=2, ADDR_CLEAR=3.
  - STATUS bit positions: ST_VALID=0, ST_PEND=1, ST_OVF=2, ST_CNT_LSB=16.
  - State enum {IDLE, SENT, SENT_PEND}.
- Single module. No sub-module: the handshake FSM and register file are too tightly coupled to split usefully.

Test Plan:
- Reset, then read addresses 0 and 1, WIDTH=8, RESET_VALUE=0 -> readdata 0x0 and 0x0; out_valid=0.
- Write 0x5A to address 0, out_ready held 0 -> next cycle out_port=0x5A, out_valid=1. Raise out_ready for 1 cycle -> out_valid=0; STATUS read = 0x00010000.
- With out_ready=0:
  - Write 0x11 to address 0, then 0x22 -> out_port stays 0x11, STATUS bit1=1.
  - Then write 0x33 -> overflow=1, STATUS=0x00000007.
  - Pulse out_ready -> out_port=0x33, still valid.
  - Pulse again -> IDLE, xfer_count=2.
- Data 0xF0 delivered, then write 0x0F to SET -> out_port=0xFF. Then write 0x81 to CLEAR -> out_port=0x7E after delivery. Reads of addresses 2 and 3 return 0.
- Write to address 0 in the same cycle as a transfer in SENT -> new value on out_port the next cycle, out_valid stays 1, overflow=0. Repeat in SENT_PEND -> overflow=1. Write 0x4 to STATUS -> overflow=0.
- Assert reset_n=0 asynchronously mid-cycle while in SENT_PEND -> out_valid, out_port, STATUS and readdata go to 0 immediately. 65536 transfers -> xfer_count wraps to 0.

Source files
------------

// File: rtl/computer_system_pio_dispatch_pkg.sv
// Shared constants for the output PIO: register map, STATUS bit layout,
// and the delivery handshake states.
package pio_dispatch_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_SET    = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    localparam int ST_VALID   = 0;
    localparam int ST_PEND    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        SENT,
        SENT_PEND
    } state_t;

endpackage

// File: rtl/computer_system_pio_dispatch.sv
// Avalon-MM output PIO: HPS writes are handed to fabric over valid/ready,
// with a one-deep pending buffer, sticky overflow and a transfer counter.
module computer_system_pio_dispatch
    import pio_dispatch_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] data_reg, data_next, port_nx, wd;
    logic             wr, load, xfer, pending, port_ld, ovf_set, ovf_clr, overflow;
    logic [15:0]      xfer_count;
    logic [31:0]      status, rd_mux;
    logic             unused_wd;

    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign wr        = chipselect & ~write_n;
    assign load      = wr && (address != ADDR_STATUS);
    assign xfer      = out_valid & out_ready;
    assign ovf_clr   = wr && (address == ADDR_STATUS) && writedata[ST_OVF];

    always_comb begin
        data_next = data_reg;
        if (load) begin
            case (address)
                ADDR_DATA:  data_next = wd;
                ADDR_SET:   data_next = data_reg | wd;
                ADDR_CLEAR: data_next = data_reg & ~wd;
                default:    data_next = data_reg;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state plus the out_port load decision that goes with each arc
    always_comb begin
        state_nx = state;
        port_ld  = 1'b0;
        port_nx  = data_next;
        ovf_set  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    port_ld  = 1'b1;
                    state_nx = SENT;
                end
            end
            SENT: begin
                if (xfer && load) port_ld  = 1'b1;
                else if (xfer)    state_nx = IDLE;
                else if (load)    state_nx = SENT_PEND;
            end
            SENT_PEND: begin
                if (xfer && load) begin
                    port_ld  = 1'b1;
                    ovf_set  = 1'b1;
                    state_nx = SENT;
                end else if (xfer) begin
                    port_ld  = 1'b1;
                    port_nx  = data_reg;
                    state_nx = SENT;
                end else if (load) begin
                    ovf_set  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state != IDLE);
        pending   = (state == SENT_PEND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg   <= RESET_VALUE;
            out_port   <= RESET_VALUE;
            overflow   <= 1'b0;
            xfer_count <= '0;
        end else begin
            if (load)    data_reg   <= data_next;
            if (port_ld) out_port   <= port_nx;
            if (xfer)    xfer_count <= xfer_count + 16'd1;
            // A supersede in the same cycle as a clear must leave the flag set
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_comb begin
        status                        = '0;
        status[ST_VALID]              = out_valid;
        status[ST_PEND]               = pending;
        status[ST_OVF]                = overflow;
        status[ST_CNT_LSB +: 16]      = xfer_count;
        case (address)
            ADDR_DATA:   rd_mux = {{(32-WIDTH){1'b0}}, data_reg};
            ADDR_STATUS: rd_mux = status;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule
